// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter: a registered grant FSM with tie-break on the last owner,
// a combinational slave-side mux, and a sticky flag for grants held too long while contested.
module bus_arbiter_2m #(
    parameter int unsigned MAX_HOLD     = 255,
    parameter int unsigned HANDOVER_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_bus_req,
    input  logic       m1_bus_req,
    output logic       m0_bus_grant,
    output logic       m1_bus_grant,
    input  logic [7:0] m0_mst2slv_addr,
    input  logic       m0_mst2slv_wr,
    input  logic       m0_mst2slv_rd,
    input  logic [7:0] m0_mst2slv_data,
    input  logic [7:0] m1_mst2slv_addr,
    input  logic       m1_mst2slv_wr,
    input  logic       m1_mst2slv_rd,
    input  logic [7:0] m1_mst2slv_data,
    output logic [7:0] s_mst2slv_addr,
    output logic       s_mst2slv_wr,
    output logic       s_mst2slv_rd,
    output logic [7:0] s_mst2slv_data,
    input  logic [7:0] s_slv2mst_data,
    output logic [7:0] m0_slv2mst_data,
    output logic [7:0] m1_slv2mst_data,
    output logic [1:0] bus_owner,
    output logic       hold_err,
    input  logic       hold_err_clr
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;
    localparam logic [1:0] GAP  = 2'b11;

    localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

    logic [1:0] state_q, state_d;
    logic       gnt0_q, gnt1_q;
    logic [1:0] owner_q;
    logic       last_q, last_d;       // 0: master 0 owned last, 1: master 1
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] hold_cnt_inc;
    logic       hold_err_q, hold_err_d;
    logic [1:0] idle_pick;
    logic       granted_q;
    logic       entering;
    logic       other_req;

    // Arbitration from an empty bus; ties go to whichever master did not own it last.
    always_comb begin
        idle_pick = IDLE;
        if (m0_bus_req && m1_bus_req) begin
            idle_pick = last_q ? GNT0 : GNT1;
        end else if (m0_bus_req) begin
            idle_pick = GNT0;
        end else if (m1_bus_req) begin
            idle_pick = GNT1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GNT0: begin
                if (!m0_bus_req) begin
                    if (HANDOVER_GAP != 0)
                        state_d = GAP;
                    else
                        state_d = m1_bus_req ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_bus_req) begin
                    if (HANDOVER_GAP != 0)
                        state_d = GAP;
                    else
                        state_d = m0_bus_req ? GNT0 : IDLE;
                end
            end
            default: state_d = idle_pick;
        endcase
    end

    always_comb begin
        granted_q    = (state_q == GNT0) || (state_q == GNT1);
        entering     = ((state_d == GNT0) && (state_q != GNT0)) ||
                       ((state_d == GNT1) && (state_q != GNT1));
        other_req    = (state_q == GNT0) ? m1_bus_req : m0_bus_req;
        hold_cnt_inc = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

        last_d = last_q;
        if (state_d == GNT0)
            last_d = 1'b0;
        else if (state_d == GNT1)
            last_d = 1'b1;

        hold_cnt_d = hold_cnt_q;
        if (entering)
            hold_cnt_d = 8'd0;
        else if (granted_q)
            hold_cnt_d = hold_cnt_inc;

        // A set in the same cycle as a clear must win.
        hold_err_d = hold_err_q && !hold_err_clr;
        if (granted_q && (hold_cnt_inc >= MAX_HOLD_L) && other_req)
            hold_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            owner_q    <= 2'b00;
            last_q     <= 1'b1;
            hold_cnt_q <= 8'd0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt0_q     <= (state_d == GNT0);
            gnt1_q     <= (state_d == GNT1);
            owner_q    <= {(state_d == GNT1), (state_d == GNT0)};
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

    always_comb begin
        s_mst2slv_addr = 8'd0;
        s_mst2slv_wr   = 1'b0;
        s_mst2slv_rd   = 1'b0;
        s_mst2slv_data = 8'd0;
        if (gnt0_q) begin
            s_mst2slv_addr = m0_mst2slv_addr;
            s_mst2slv_wr   = m0_mst2slv_wr;
            s_mst2slv_rd   = m0_mst2slv_rd;
            s_mst2slv_data = m0_mst2slv_data;
        end else if (gnt1_q) begin
            s_mst2slv_addr = m1_mst2slv_addr;
            s_mst2slv_wr   = m1_mst2slv_wr;
            s_mst2slv_rd   = m1_mst2slv_rd;
            s_mst2slv_data = m1_mst2slv_data;
        end
    end

    assign m0_slv2mst_data = s_slv2mst_data;
    assign m1_slv2mst_data = s_slv2mst_data;
    assign m0_bus_grant    = gnt0_q;
    assign m1_bus_grant    = gnt1_q;
    assign bus_owner       = owner_q;
    assign hold_err        = hold_err_q;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: instance 0 has a handover gap, instance 1 hands over back-to-back;
// both use MAX_HOLD=4 and share stimulus, checked against a tenure-level reference model.
module tb_bus_arbiter_2m;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, r0, r1, clr;
    logic [7:0] a0, a1, d0, d1, sd;
    logic       w0, rd0, w1, rd1;

    logic [1:0] gnt0, gnt1, herr;
    logic [1:0] owner [2];
    logic [7:0] s_addr [2];
    logic [7:0] s_data [2];
    logic [1:0] s_wr, s_rd;
    logic [7:0] rdat0 [2];
    logic [7:0] rdat1 [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            bus_arbiter_2m #(
                .MAX_HOLD    (4),
                .HANDOVER_GAP((gi == 0) ? 1 : 0)
            ) dut (
                .clk            (clk),
                .rst            (rst),
                .m0_bus_req     (r0),
                .m1_bus_req     (r1),
                .m0_bus_grant   (gnt0[gi]),
                .m1_bus_grant   (gnt1[gi]),
                .m0_mst2slv_addr(a0),
                .m0_mst2slv_wr  (w0),
                .m0_mst2slv_rd  (rd0),
                .m0_mst2slv_data(d0),
                .m1_mst2slv_addr(a1),
                .m1_mst2slv_wr  (w1),
                .m1_mst2slv_rd  (rd1),
                .m1_mst2slv_data(d1),
                .s_mst2slv_addr (s_addr[gi]),
                .s_mst2slv_wr   (s_wr[gi]),
                .s_mst2slv_rd   (s_rd[gi]),
                .s_mst2slv_data (s_data[gi]),
                .s_slv2mst_data (sd),
                .m0_slv2mst_data(rdat0[gi]),
                .m1_slv2mst_data(rdat1[gi]),
                .bus_owner      (owner[gi]),
                .hold_err       (herr[gi]),
                .hold_err_clr   (clr)
            );
        end
    endgenerate

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus (0 none, 1 master 0, 2 master 1), who owned it last,
    // how many cycles the current tenure has completed, and the sticky error.
    int m_owner [2];
    int m_last  [2];
    int m_held  [2];
    bit m_err   [2];
    int starve  [2][2];
    bit prev_g  [2][2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_owner[k] = 0;
                m_last[k]  = 2;
                m_held[k]  = 0;
                m_err[k]   = 1'b0;
            end else begin
                bit set_e;
                bit req_me, req_oth;
                int held_next;
                set_e = 1'b0;
                if (m_owner[k] != 0) begin
                    req_me    = (m_owner[k] == 1) ? r0 : r1;
                    req_oth   = (m_owner[k] == 1) ? r1 : r0;
                    held_next = (m_held[k] >= 255) ? 255 : m_held[k] + 1;
                    set_e     = (held_next >= 4) && req_oth;
                    m_held[k] = held_next;
                    if (!req_me) begin
                        if (k == 0 || !req_oth) begin
                            m_owner[k] = 0;
                        end else begin
                            m_owner[k] = 3 - m_owner[k];
                            m_last[k]  = m_owner[k];
                            m_held[k]  = 0;
                        end
                    end
                end else begin
                    int pick;
                    pick = 0;
                    if (r0 && r1)  pick = 3 - m_last[k];
                    else if (r0)   pick = 1;
                    else if (r1)   pick = 2;
                    if (pick != 0) begin
                        m_owner[k] = pick;
                        m_last[k]  = pick;
                        m_held[k]  = 0;
                    end
                end
                m_err[k] = set_e || (m_err[k] && !clr);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e_addr, e_data;
            logic       e_wr, e_rd;
            e_addr = 8'd0; e_data = 8'd0; e_wr = 1'b0; e_rd = 1'b0;
            if (m_owner[k] == 1) begin
                e_addr = a0; e_data = d0; e_wr = w0; e_rd = rd0;
            end else if (m_owner[k] == 2) begin
                e_addr = a1; e_data = d1; e_wr = w1; e_rd = rd1;
            end
            chk("gnt0", k, gnt0[k], m_owner[k] == 1);
            chk("gnt1", k, gnt1[k], m_owner[k] == 2);
            chk("excl", k, gnt0[k] & gnt1[k], 0);
            chk("owner", k, owner[k], m_owner[k]);
            chk("hold_err", k, herr[k], m_err[k]);
            chk("s_addr", k, s_addr[k], e_addr);
            chk("s_data", k, s_data[k], e_data);
            chk("s_wr", k, s_wr[k], e_wr);
            chk("s_rd", k, s_rd[k], e_rd);
            chk("rdata0", k, rdat0[k], sd);
            chk("rdata1", k, rdat1[k], sd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; r0 = 1'b1; r1 = 1'b1; clr = 1'b0;
        a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00; sd = 8'h5A;
        w0 = 1'b0; rd0 = 1'b0; w1 = 1'b0; rd1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0; m_last[k] = 2; m_held[k] = 0; m_err[k] = 1'b0;
        end
        @(negedge clk);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_owner", k, owner[k], 2'b00);
            chk("rst_gnt", k, {gnt1[k], gnt0[k]}, 2'b00);
            chk("rst_err", k, herr[k], 1'b0);
        end

        // Both requests held through reset: master 0 wins the first tie.
        rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) chk("tie_gnt0", k, {gnt1[k], gnt0[k]}, 2'b01);
        r0 = 1'b0;
        step();
        chk("gap_idle", 0, {gnt1[0], gnt0[0]}, 2'b00);
        chk("b2b_gnt1", 1, {gnt1[1], gnt0[1]}, 2'b10);
        step();
        chk("after_gap_gnt1", 0, {gnt1[0], gnt0[0]}, 2'b10);

        // Granted master 1 drives the slave; master 0's activity must not leak through.
        a1 = 8'h3C; w1 = 1'b1; d1 = 8'hA5; a0 = 8'hFF; rd0 = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mux_addr", k, s_addr[k], 8'h3C);
            chk("mux_wr", k, s_wr[k], 1'b1);
            chk("mux_rd", k, s_rd[k], 1'b0);
            chk("mux_data", k, s_data[k], 8'hA5);
        end
        r1 = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("nogrant_slave", k, {s_addr[k], s_data[k], s_wr[k], s_rd[k]}, 18'd0);
        end
        step();

        // Contested hold: flag appears after the 4th held cycle and survives a clear.
        r0 = 1'b1;
        step();
        r1 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        for (int k = 0; k < 2; k++) chk("err_before_limit", k, herr[k], 1'b0);
        step();
        for (int k = 0; k < 2; k++) chk("err_at_limit", k, herr[k], 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) chk("err_clr_loses", k, herr[k], 1'b1);
        r0 = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) chk("err_cleared", k, herr[k], 1'b0);

        // Reset in the middle of a master-0 tenure, then only master 1 requesting.
        r1 = 1'b0;
        step();
        step();
        r0 = 1'b1;
        step();
        for (int k = 0; k < 2; k++) chk("pre_rst_gnt0", k, gnt0[k], 1'b1);
        rst = 1'b1; r0 = 1'b0; r1 = 1'b1; w0 = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_drop_gnt", k, {gnt1[k], gnt0[k]}, 2'b00);
            chk("rst_strobes", k, {s_wr[k], s_rd[k]}, 2'b00);
        end
        rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) chk("post_rst_gnt1", k, {gnt1[k], gnt0[k]}, 2'b10);

        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < 2; x++) begin
                starve[k][x] = 0;
                prev_g[k][x] = (x == 0) ? gnt0[k] : gnt1[k];
            end
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 7) == 0) r0 = ~r0;
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 999) == 0);
            a0 = 8'($urandom); a1 = 8'($urandom);
            d0 = 8'($urandom); d1 = 8'($urandom);
            sd = 8'($urandom);
            {w0, rd0, w1, rd1} = 4'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                for (int x = 0; x < 2; x++) begin
                    logic own, oth, rq;
                    own = (x == 0) ? gnt0[k] : gnt1[k];
                    oth = (x == 0) ? gnt1[k] : gnt0[k];
                    rq  = (x == 0) ? r0 : r1;
                    if (rst || own || !rq)
                        starve[k][x] = 0;
                    else if (oth && !prev_g[k][1-x])
                        starve[k][x]++;
                    chk("starve", k, starve[k][x] <= 1, 1'b1);
                end
                prev_g[k][0] = gnt0[k];
                prev_g[k][1] = gnt1[k];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2m.md
BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 255: grant-hold cycle limit for the overrun flag, range 1..255.
REQ-002 SHALL provide parameter HANDOVER_GAP, default 1: 1 inserts one idle cycle between grants, 0 allows back-to-back handover.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_bus_req, m1_bus_req  input  1 each  bus request from master 0 (CPU) and master 1.
REQ-006 m0_bus_grant, m1_bus_grant  output  1 each  registered grant to each master.
REQ-007 m0_mst2slv_addr, m1_mst2slv_addr  input  8 each  master address buses.
REQ-008 m0_mst2slv_wr/rd, m1_mst2slv_wr/rd  input  1 each  master write and read strobes.
REQ-009 m0_mst2slv_data, m1_mst2slv_data  input  8 each  master write data.
REQ-010 s_mst2slv_addr  output  8  address bus to slaves.
REQ-011 s_mst2slv_wr, s_mst2slv_rd  output  1 each  write and read strobes to slaves.
REQ-012 s_mst2slv_data  output  8  write data to slaves.
REQ-013 s_slv2mst_data  input  8  read data from slaves.
REQ-014 m0_slv2mst_data, m1_slv2mst_data  output  8 each  read data to each master.
REQ-015 bus_owner  output  2  00 none, 01 master 0, 10 master 1.
REQ-016 hold_err  output  1  sticky grant-overrun flag.
REQ-017 hold_err_clr  input  1  clears hold_err.

Function
REQ-018 The FSM SHALL have four states: IDLE, GNT0, GNT1, GAP; m0_bus_grant SHALL be 1 exactly in GNT0, m1_bus_grant exactly in GNT1, and the two grants SHALL never be high together.
REQ-019 IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> the master not in register last_owner; neither -> stay; grant rises one cycle after the request is sampled.
REQ-020 GNTx: stay while reqx=1, with no preemption regardless of the other request.
REQ-021 GNTx on reqx=0 with HANDOVER_GAP=1: -> GAP.
REQ-022 GNTx on reqx=0 with HANDOVER_GAP=0: -> GNT of the other master if its req=1, else -> IDLE.
REQ-023 GAP SHALL last exactly one cycle with both grants low, then apply the IDLE decision rules.
REQ-024 last_owner SHALL update to x on every entry into GNTx.
REQ-025 Slave-side outputs SHALL be combinational: when the grant for x is high, each s_mst2slv_* output SHALL equal the corresponding mx_* input.
REQ-026 With no grant high, all s_mst2slv_* outputs SHALL be 0.
REQ-027 An ungranted master's inputs SHALL be ignored even if non-zero.
REQ-028 s_slv2mst_data SHALL be driven to both m0_slv2mst_data and m1_slv2mst_data unconditionally with zero latency.
REQ-029 An 8-bit hold_cnt SHALL clear on grant entry and increment each cycle a grant is held, saturating at 255.
REQ-030 hold_err SHALL set on the cycle hold_cnt reaches MAX_HOLD while the other master's req=1; the grant itself is unaffected.
REQ-031 hold_err_clr SHALL clear hold_err; if clear and set occur in the same cycle, set SHALL win.
REQ-032 bus_owner SHALL be registered and consistent with the grants in the same cycle.

Reset
REQ-033 On rst=1 at a clock edge: state IDLE, both grants 0, bus_owner 00, hold_err 0, hold_cnt 0, last_owner = master 1 (so master 0 wins the first tie).
REQ-034 rst asserted mid-grant SHALL drop the grant on that edge, with slave-side strobes 0 in the following cycle.
REQ-035 Requests held high through reset SHALL be arbitrated from IDLE on the first cycle after rst deasserts.

Verification
REQ-036 After reset, req0=req1=1 together: m0_bus_grant=1 next cycle; drop req0 with GAP=1 -> one cycle with no grant, then m1_bus_grant=1.
REQ-037 HANDOVER_GAP=0, req1 held, req0 drops in GNT0: m1_bus_grant=1 on the very next cycle, with no idle cycle.
REQ-038 GNT1 with m1 addr=0x3C, wr=1, data=0xA5 and m0 driving addr=0xFF, rd=1: slave sees addr 0x3C, wr 1, rd 0, data 0xA5; with no grant, slave sees all zeros.
REQ-039 MAX_HOLD=4, master 0 holds while req1=1: hold_err=1 after the 4th held cycle; pulsing hold_err_clr while the condition persists keeps it 1; clr after release -> 0.
REQ-040 rst pulse during GNT0: grant 0 on the next cycle; with req1=1, the first grant after reset goes to master 1 since only req1 is high.
REQ-041 Randomized req toggling over 10k cycles: grants never both high, no starvation beyond one competing tenure, bus_owner always matches the grants.
